// File: rtl/test_pattern_pkg.sv
// Shared definitions for the test pattern generator: pattern codes, FSM encoding and PRBS polynomial.
package test_pattern_pkg;

  typedef enum logic [2:0] {
    TPG_RAMP    = 3'd0,
    TPG_BAR     = 3'd1,
    TPG_CHECKER = 3'd2,
    TPG_SOLID   = 3'd3,
    TPG_PRBS    = 3'd4
  } tpg_mode_e;

  localparam int S_IDLE   = 0;
  localparam int S_VBLANK = 1;
  localparam int S_HBLANK = 2;
  localparam int S_ACTIVE = 3;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'b0001,
    ST_VBLANK = 4'b0010,
    ST_HBLANK = 4'b0100,
    ST_ACTIVE = 4'b1000
  } tpg_state_e;

  // Fibonacci x^16+x^14+x^13+x^11+1, shifting right: feedback from bits 0,2,3,5.
  localparam logic [15:0] LFSR_TAPS = 16'h002D;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {^(s & LFSR_TAPS), s[15:1]};
  endfunction

endpackage

// File: rtl/tpg_pixel_src.sv
// Pixel source: owns the PRBS LFSR and per-frame ramp seed, and computes the pixel
// for the coordinate about to be presented on the output register.
module tpg_pixel_src
  import test_pattern_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int CNT_W    = 12,
  parameter int BAR_LOG2 = 5,
  parameter int CHK_LOG2 = 3
) (
  input  logic              im_pclk,
  input  logic              rst_n,
  input  logic              frame_load_i,
  input  logic [DATA_W-1:0] seed_i,
  input  logic              advance_i,
  input  logic [2:0]        mode_i,
  input  logic [DATA_W-1:0] solid_i,
  input  logic [CNT_W-1:0]  x_i,
  input  logic [CNT_W-1:0]  y_i,
  output logic [DATA_W-1:0] pixel_o
);

  logic [15:0]       lfsr_q;
  logic [15:0]       lfsr_d;
  logic [DATA_W-1:0] seed_q;
  logic [DATA_W-1:0] seed_d;
  logic [DATA_W-1:0] x_lo;
  logic [DATA_W-1:0] ramp_pix;
  logic [2:0]        bar_idx;
  logic [DATA_W-1:0] bar_pix;
  logic              chk_on;
  logic [DATA_W-1:0] chk_pix;

  // lfsr_q always holds the value for the next valid pixel to be loaded.
  always_comb begin
    lfsr_d = lfsr_q;
    seed_d = seed_q;
    if (frame_load_i) begin
      lfsr_d = LFSR_SEED;
      seed_d = seed_i;
    end else if (advance_i) begin
      lfsr_d = lfsr_step(lfsr_q);
    end
  end

  always_ff @(posedge im_pclk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= LFSR_SEED;
      seed_q <= '0;
    end else begin
      lfsr_q <= lfsr_d;
      seed_q <= seed_d;
    end
  end

  generate
    if (CNT_W >= DATA_W) begin : g_x_trunc
      assign x_lo = x_i[DATA_W-1:0];
    end else begin : g_x_ext
      assign x_lo = DATA_W'(x_i);
    end
  endgenerate

  assign ramp_pix = seed_q + x_lo;
  assign bar_idx  = x_i[BAR_LOG2+2:BAR_LOG2];
  assign bar_pix  = {bar_idx, {(DATA_W-3){bar_idx[0]}}};
  assign chk_on   = x_i[CHK_LOG2] ^ y_i[CHK_LOG2];
  assign chk_pix  = chk_on ? {DATA_W{1'b1}} : '0;

  always_comb begin
    pixel_o = '0;
    case (mode_i)
      TPG_RAMP:    pixel_o = ramp_pix;
      TPG_BAR:     pixel_o = bar_pix;
      TPG_CHECKER: pixel_o = chk_pix;
      TPG_SOLID:   pixel_o = solid_i;
      TPG_PRBS:    pixel_o = lfsr_q[DATA_W-1:0];
      default:     pixel_o = '0;
    endcase
  end

endmodule

// File: rtl/test_pattern_gen.sv
// Video test pattern generator: run-time frame geometry, selectable patterns, start/stop
// control and completed-frame counter. Outputs are registered from the next state.
module test_pattern_gen
  import test_pattern_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int CNT_W    = 12,
  parameter int BAR_LOG2 = 5,
  parameter int CHK_LOG2 = 3
) (
  input  logic              im_pclk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [2:0]        cfg_mode,
  input  logic [CNT_W-1:0]  cfg_rows,
  input  logic [CNT_W-1:0]  cfg_cols,
  input  logic [CNT_W-1:0]  cfg_vblank,
  input  logic [CNT_W-1:0]  cfg_hblank,
  input  logic [DATA_W-1:0] cfg_solid,
  output logic              im_vsync,
  output logic              im_hsync,
  output logic              im_valid,
  output logic [DATA_W-1:0] im_dout,
  output logic              frame_start,
  output logic              frame_end,
  output logic [15:0]       frame_cnt
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  tpg_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  col_q, col_d;
  logic [CNT_W-1:0]  row_q, row_d;
  logic              load_cfg;

  logic [CNT_W-1:0]  rows_q, cols_q, vblank_q, hblank_q;
  logic [2:0]        mode_q;
  logic [DATA_W-1:0] solid_q;

  logic              vsync_q, hsync_q, valid_q;
  logic [DATA_W-1:0] dout_q;
  logic              frame_start_q, frame_end_q;
  logic [15:0]       frame_cnt_q;

  logic              active_d;
  logic              last_pix_d;
  logic [DATA_W-1:0] pixel;

  function automatic logic [CNT_W-1:0] nz(input logic [CNT_W-1:0] v);
    return (v == '0) ? ONE : v;
  endfunction

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    col_d    = col_q;
    row_d    = row_q;
    load_cfg = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        col_d = '0;
        row_d = '0;
        if (en) begin
          state_d  = ST_VBLANK;
          load_cfg = 1'b1;
        end
      end
      ST_VBLANK: begin
        if (cnt_q == vblank_q - ONE) begin
          state_d = ST_HBLANK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      ST_HBLANK: begin
        if (cnt_q == hblank_q - ONE) begin
          cnt_d = '0;
          col_d = '0;
          if (row_q < rows_q) begin
            state_d = ST_ACTIVE;
          end else begin
            // Trailing blank done: a frame is never cut short, en only decides what follows.
            row_d = '0;
            if (en) begin
              state_d  = ST_VBLANK;
              load_cfg = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      ST_ACTIVE: begin
        if (col_q == cols_q - ONE) begin
          state_d = ST_HBLANK;
          col_d   = '0;
          row_d   = row_q + ONE;
        end else begin
          col_d = col_q + ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        col_d   = '0;
        row_d   = '0;
      end
    endcase
  end

  always_ff @(posedge im_pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      col_q   <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      col_q   <= col_d;
      row_q   <= row_d;
    end
  end

  // Geometry of zero is promoted to one so every frame has at least one pixel.
  always_ff @(posedge im_pclk or negedge rst_n) begin
    if (!rst_n) begin
      rows_q   <= ONE;
      cols_q   <= ONE;
      vblank_q <= ONE;
      hblank_q <= ONE;
      mode_q   <= 3'd0;
      solid_q  <= '0;
    end else if (load_cfg) begin
      rows_q   <= nz(cfg_rows);
      cols_q   <= nz(cfg_cols);
      vblank_q <= nz(cfg_vblank);
      hblank_q <= nz(cfg_hblank);
      mode_q   <= cfg_mode;
      solid_q  <= cfg_solid;
    end
  end

  assign active_d   = state_d[S_ACTIVE];
  assign last_pix_d = active_d && (col_d == cols_q - ONE) && (row_d == rows_q - ONE);

  tpg_pixel_src #(
    .DATA_W   (DATA_W),
    .CNT_W    (CNT_W),
    .BAR_LOG2 (BAR_LOG2),
    .CHK_LOG2 (CHK_LOG2)
  ) u_pixel_src (
    .im_pclk      (im_pclk),
    .rst_n        (rst_n),
    .frame_load_i (load_cfg),
    .seed_i       (frame_cnt_q[DATA_W-1:0]),
    .advance_i    (active_d),
    .mode_i       (mode_q),
    .solid_i      (solid_q),
    .x_i          (col_d),
    .y_i          (row_d),
    .pixel_o      (pixel)
  );

  always_ff @(posedge im_pclk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q       <= 1'b1;
      hsync_q       <= 1'b1;
      valid_q       <= 1'b0;
      dout_q        <= '0;
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      vsync_q       <= state_d[S_IDLE] | state_d[S_VBLANK];
      hsync_q       <= ~active_d;
      valid_q       <= active_d;
      dout_q        <= active_d ? pixel : '0;
      frame_start_q <= load_cfg;
      frame_end_q   <= last_pix_d;
      if (frame_end_q) begin
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end
    end
  end

  assign im_vsync    = vsync_q;
  assign im_hsync    = hsync_q;
  assign im_valid    = valid_q;
  assign im_dout     = dout_q;
  assign frame_start = frame_start_q;
  assign frame_end   = frame_end_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_test_pattern_gen.sv
// Directed bench for test_pattern_gen: frame timing, each pattern, start/stop, cfg latching, async reset.
module tb_test_pattern_gen;
  import test_pattern_pkg::*;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 12;

  logic              im_pclk = 1'b0;
  logic              rst_n   = 1'b0;
  logic              en      = 1'b0;
  logic [2:0]        cfg_mode   = '0;
  logic [CNT_W-1:0]  cfg_rows   = '0;
  logic [CNT_W-1:0]  cfg_cols   = '0;
  logic [CNT_W-1:0]  cfg_vblank = '0;
  logic [CNT_W-1:0]  cfg_hblank = '0;
  logic [DATA_W-1:0] cfg_solid  = '0;
  logic              im_vsync, im_hsync, im_valid;
  logic [DATA_W-1:0] im_dout;
  logic              frame_start, frame_end;
  logic [15:0]       frame_cnt;

  int total = 0;
  int bad   = 0;

  int   cap_len, cap_nv, cap_nfe, cap_fe_idx, cap_dirty;
  bit   cap_fe_on_valid;
  logic [7:0] pix [0:255];
  logic [7:0] exp_prbs [0:7];

  test_pattern_gen #(
    .DATA_W   (DATA_W),
    .CNT_W    (CNT_W),
    .BAR_LOG2 (1),
    .CHK_LOG2 (1)
  ) dut (
    .im_pclk     (im_pclk),
    .rst_n       (rst_n),
    .en          (en),
    .cfg_mode    (cfg_mode),
    .cfg_rows    (cfg_rows),
    .cfg_cols    (cfg_cols),
    .cfg_vblank  (cfg_vblank),
    .cfg_hblank  (cfg_hblank),
    .cfg_solid   (cfg_solid),
    .im_vsync    (im_vsync),
    .im_hsync    (im_hsync),
    .im_valid    (im_valid),
    .im_dout     (im_dout),
    .frame_start (frame_start),
    .frame_end   (frame_end),
    .frame_cnt   (frame_cnt)
  );

  always #5 im_pclk = ~im_pclk;

  task automatic apply_reset();
    rst_n = 1'b0;
    en    = 1'b0;
    repeat (2) @(negedge im_pclk);
    rst_n = 1'b1;
    @(negedge im_pclk);
  endtask

  task automatic set_cfg(input logic [2:0] m, input int r, input int c, input int v, input int h,
                         input logic [7:0] s);
    cfg_mode   = m;
    cfg_rows   = CNT_W'(r);
    cfg_cols   = CNT_W'(c);
    cfg_vblank = CNT_W'(v);
    cfg_hblank = CNT_W'(h);
    cfg_solid  = s;
  endtask

  task automatic wait_fs();
    bit found;
    found = 1'b0;
    for (int k = 0; k < 500; k++) begin
      if (frame_start === 1'b1) begin
        found = 1'b1;
        break;
      end
      @(negedge im_pclk);
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL wait_frame_start: got no frame_start, required one within 500 cycles");
    end
  endtask

  // Records one frame starting at the current frame_start cycle; hook fires when hook_at pixels are seen.
  task automatic capture(input int hook_at, input int hook_kind);
    bit seen_end, done;
    cap_len = 0; cap_nv = 0; cap_nfe = 0; cap_fe_idx = -1; cap_dirty = 0; cap_fe_on_valid = 1'b0;
    seen_end = 1'b0; done = 1'b0;
    for (int k = 0; k < 4000; k++) begin
      if (im_valid === 1'b1) begin
        pix[cap_nv] = im_dout;
        cap_nv++;
        if (cap_nv == hook_at && hook_kind == 1) en = 1'b0;
        if (cap_nv == hook_at && hook_kind == 2) cfg_cols = CNT_W'(4);
      end else if (im_dout !== '0) begin
        cap_dirty++;
      end
      if (frame_end === 1'b1) begin
        cap_nfe++;
        cap_fe_idx = cap_nv;
        cap_fe_on_valid = im_valid;
        seen_end = 1'b1;
      end
      @(negedge im_pclk);
      cap_len++;
      if (seen_end && im_vsync === 1'b1) begin
        done = 1'b1;
        break;
      end
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL capture_timeout: frame did not end, required end within 4000 cycles");
    end
  endtask

  task automatic test_reset();
    apply_reset();
    total += 7;
    if (im_vsync !== 1'b1)    begin bad++; $display("FAIL reset_vsync: got %b want 1", im_vsync); end
    if (im_hsync !== 1'b1)    begin bad++; $display("FAIL reset_hsync: got %b want 1", im_hsync); end
    if (im_valid !== 1'b0)    begin bad++; $display("FAIL reset_valid: got %b want 0", im_valid); end
    if (im_dout !== 8'h00)    begin bad++; $display("FAIL reset_dout: got %h want 00", im_dout); end
    if (frame_start !== 1'b0) begin bad++; $display("FAIL reset_fstart: got %b want 0", frame_start); end
    if (frame_end !== 1'b0)   begin bad++; $display("FAIL reset_fend: got %b want 0", frame_end); end
    if (frame_cnt !== 16'd0)  begin bad++; $display("FAIL reset_fcnt: got %0d want 0", frame_cnt); end
    $display("reset: vsync=%b hsync=%b valid=%b cnt=%0d", im_vsync, im_hsync, im_valid, frame_cnt);
  endtask

  task automatic test_ramp();
    apply_reset();
    set_cfg(3'd0, 4, 8, 3, 2, 8'h00);
    en = 1'b1;
    wait_fs();
    for (int f = 0; f < 2; f++) begin
      capture(0, 0);
      total += 7;
      if (cap_len != 45)  begin bad++; $display("FAIL ramp_len f%0d: got %0d want 45", f, cap_len); end
      if (cap_nv != 32)   begin bad++; $display("FAIL ramp_valid f%0d: got %0d want 32", f, cap_nv); end
      if (cap_nfe != 1)   begin bad++; $display("FAIL ramp_fend f%0d: got %0d want 1", f, cap_nfe); end
      if (cap_fe_idx != 32 || !cap_fe_on_valid)
        begin bad++; $display("FAIL ramp_fend_pos f%0d: got idx %0d valid %b want 32/1", f, cap_fe_idx, cap_fe_on_valid); end
      if (cap_dirty != 0) begin bad++; $display("FAIL ramp_blank_dout f%0d: got %0d nonzero want 0", f, cap_dirty); end
      if (frame_start !== 1'b1) begin bad++; $display("FAIL ramp_next_fstart f%0d: got %b want 1", f, frame_start); end
      if (frame_cnt !== 16'(f + 1)) begin bad++; $display("FAIL ramp_fcnt f%0d: got %0d want %0d", f, frame_cnt, f + 1); end
      for (int i = 0; i < 32; i++) begin
        total++;
        if (pix[i] !== 8'(f + (i % 8)))
          begin bad++; $display("FAIL ramp_pix f%0d i%0d: got %h want %h", f, i, pix[i], 8'(f + (i % 8))); end
      end
      $display("ramp frame %0d: len=%0d valid=%0d first=%h", f, cap_len, cap_nv, pix[0]);
    end
  endtask

  task automatic test_bar();
    logic [2:0] b;
    logic [7:0] e;
    apply_reset();
    set_cfg(3'd1, 1, 16, 1, 1, 8'h00);
    en = 1'b1;
    wait_fs();
    capture(0, 0);
    total += 4;
    if (cap_len != 19) begin bad++; $display("FAIL bar_len: got %0d want 19", cap_len); end
    if (cap_nv != 16)  begin bad++; $display("FAIL bar_valid: got %0d want 16", cap_nv); end
    if (pix[2] !== 8'h3F)  begin bad++; $display("FAIL bar_b1: got %h want 3F", pix[2]); end
    if (pix[15] !== 8'hFF) begin bad++; $display("FAIL bar_b7: got %h want FF", pix[15]); end
    for (int i = 0; i < 16; i++) begin
      b = 3'(i / 2);
      e = {b, {5{b[0]}}};
      total++;
      if (pix[i] !== e) begin bad++; $display("FAIL bar_pix x%0d: got %h want %h", i, pix[i], e); end
    end
    $display("bar: len=%0d x2=%h x15=%h", cap_len, pix[2], pix[15]);
  endtask

  task automatic test_checker();
    logic [7:0] tbl [0:15];
    tbl = '{8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'hFF,
            8'hFF, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00};
    apply_reset();
    set_cfg(3'd2, 4, 4, 1, 1, 8'h00);
    en = 1'b1;
    wait_fs();
    capture(0, 0);
    total += 2;
    if (cap_len != 22) begin bad++; $display("FAIL chk_len: got %0d want 22", cap_len); end
    if (cap_nv != 16)  begin bad++; $display("FAIL chk_valid: got %0d want 16", cap_nv); end
    for (int i = 0; i < 16; i++) begin
      total++;
      if (pix[i] !== tbl[i]) begin bad++; $display("FAIL chk_pix %0d: got %h want %h", i, pix[i], tbl[i]); end
    end
    $display("checker: len=%0d row0=%h%h%h%h", cap_len, pix[0], pix[1], pix[2], pix[3]);
  endtask

  task automatic test_solid_reserved();
    apply_reset();
    set_cfg(3'd3, 2, 3, 1, 1, 8'h5A);
    en = 1'b1;
    wait_fs();
    cfg_solid = 8'hC3;
    capture(0, 0);
    total++;
    if (cap_nv != 6) begin bad++; $display("FAIL solid_valid: got %0d want 6", cap_nv); end
    for (int i = 0; i < 6; i++) begin
      total++;
      if (pix[i] !== 8'h5A) begin bad++; $display("FAIL solid_pix %0d: got %h want 5A", i, pix[i]); end
    end
    $display("solid: valid=%0d pix=%h", cap_nv, pix[0]);
    apply_reset();
    set_cfg(3'd5, 2, 3, 1, 1, 8'h5A);
    en = 1'b1;
    wait_fs();
    capture(0, 0);
    for (int i = 0; i < 6; i++) begin
      total++;
      if (pix[i] !== 8'h00) begin bad++; $display("FAIL reserved_pix %0d: got %h want 00", i, pix[i]); end
    end
    $display("reserved mode 5: valid=%0d pix=%h", cap_nv, pix[0]);
  endtask

  task automatic test_prbs();
    logic [15:0] lf;
    lf = 16'hACE1;
    for (int i = 0; i < 8; i++) begin
      exp_prbs[i] = lf[7:0];
      lf = {lf[0] ^ lf[2] ^ lf[3] ^ lf[5], lf[15:1]};
    end
    apply_reset();
    set_cfg(3'd4, 2, 4, 2, 1, 8'h00);
    en = 1'b1;
    wait_fs();
    for (int f = 0; f < 2; f++) begin
      capture(0, 0);
      total += 3;
      if (cap_len != 13)    begin bad++; $display("FAIL prbs_len f%0d: got %0d want 13", f, cap_len); end
      if (cap_nv != 8)      begin bad++; $display("FAIL prbs_valid f%0d: got %0d want 8", f, cap_nv); end
      if (pix[0] !== 8'hE1) begin bad++; $display("FAIL prbs_first f%0d: got %h want E1", f, pix[0]); end
      for (int i = 0; i < 8; i++) begin
        total++;
        if (pix[i] !== exp_prbs[i])
          begin bad++; $display("FAIL prbs_pix f%0d i%0d: got %h want %h", f, i, pix[i], exp_prbs[i]); end
      end
      $display("prbs frame %0d: first=%h last=%h", f, pix[0], pix[7]);
    end
  endtask

  task automatic test_zero_geom();
    apply_reset();
    set_cfg(3'd0, 0, 0, 0, 0, 8'h00);
    en = 1'b1;
    wait_fs();
    capture(0, 0);
    total += 3;
    if (cap_len != 4)     begin bad++; $display("FAIL zero_len: got %0d want 4", cap_len); end
    if (cap_nv != 1)      begin bad++; $display("FAIL zero_valid: got %0d want 1", cap_nv); end
    if (pix[0] !== 8'h00) begin bad++; $display("FAIL zero_pix: got %h want 00", pix[0]); end
    $display("zero geometry: len=%0d valid=%0d", cap_len, cap_nv);
  endtask

  task automatic test_en_drop();
    int extra;
    apply_reset();
    set_cfg(3'd0, 4, 8, 3, 2, 8'h00);
    en = 1'b1;
    wait_fs();
    capture(10, 1);
    total += 8;
    if (cap_len != 45)        begin bad++; $display("FAIL drop_len: got %0d want 45", cap_len); end
    if (cap_nv != 32)         begin bad++; $display("FAIL drop_valid: got %0d want 32", cap_nv); end
    if (cap_nfe != 1)         begin bad++; $display("FAIL drop_fend: got %0d want 1", cap_nfe); end
    if (frame_cnt !== 16'd1)  begin bad++; $display("FAIL drop_fcnt: got %0d want 1", frame_cnt); end
    if (frame_start !== 1'b0) begin bad++; $display("FAIL drop_fstart: got %b want 0", frame_start); end
    if (im_vsync !== 1'b1 || im_hsync !== 1'b1)
      begin bad++; $display("FAIL drop_idle_sync: got %b%b want 11", im_vsync, im_hsync); end
    extra = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge im_pclk);
      if (frame_start === 1'b1 || im_valid === 1'b1 || im_vsync !== 1'b1) extra++;
    end
    if (extra != 0)           begin bad++; $display("FAIL drop_stays_idle: got %0d activity cycles want 0", extra); end
    if (frame_cnt !== 16'd1)  begin bad++; $display("FAIL drop_fcnt_hold: got %0d want 1", frame_cnt); end
    $display("en drop: valid=%0d fend=%0d cnt=%0d", cap_nv, cap_nfe, frame_cnt);
  endtask

  task automatic test_cfg_change();
    apply_reset();
    set_cfg(3'd0, 4, 8, 3, 2, 8'h00);
    en = 1'b1;
    wait_fs();
    capture(5, 2);
    total += 2;
    if (cap_nv != 32)  begin bad++; $display("FAIL cfgchg_cur_valid: got %0d want 32", cap_nv); end
    if (cap_len != 45) begin bad++; $display("FAIL cfgchg_cur_len: got %0d want 45", cap_len); end
    capture(0, 0);
    total += 3;
    if (cap_nv != 16)  begin bad++; $display("FAIL cfgchg_next_valid: got %0d want 16", cap_nv); end
    if (cap_len != 29) begin bad++; $display("FAIL cfgchg_next_len: got %0d want 29", cap_len); end
    if (pix[4] !== 8'h01) begin bad++; $display("FAIL cfgchg_line2_start: got %h want 01", pix[4]); end
    $display("cfg change: next valid=%0d len=%0d", cap_nv, cap_len);
  endtask

  task automatic test_reset_mid();
    apply_reset();
    set_cfg(3'd0, 4, 8, 3, 2, 8'h00);
    en = 1'b1;
    wait_fs();
    capture(0, 0);
    repeat (7) @(negedge im_pclk);
    total++;
    if (im_valid !== 1'b1 || im_dout !== 8'h03)
      begin bad++; $display("FAIL midframe_pix: got v=%b d=%h want v=1 d=03", im_valid, im_dout); end
    rst_n = 1'b0;
    #1;
    total += 5;
    if (im_valid !== 1'b0)   begin bad++; $display("FAIL async_valid: got %b want 0", im_valid); end
    if (im_vsync !== 1'b1 || im_hsync !== 1'b1)
      begin bad++; $display("FAIL async_sync: got %b%b want 11", im_vsync, im_hsync); end
    if (im_dout !== 8'h00)   begin bad++; $display("FAIL async_dout: got %h want 00", im_dout); end
    if (frame_cnt !== 16'd0) begin bad++; $display("FAIL async_fcnt: got %0d want 0", frame_cnt); end
    if (frame_end !== 1'b0)  begin bad++; $display("FAIL async_fend: got %b want 0", frame_end); end
    @(negedge im_pclk);
    rst_n = 1'b1;
    wait_fs();
    capture(0, 0);
    total += 2;
    if (cap_nv != 32)        begin bad++; $display("FAIL restart_valid: got %0d want 32", cap_nv); end
    if (frame_cnt !== 16'd1) begin bad++; $display("FAIL restart_fcnt: got %0d want 1", frame_cnt); end
    for (int i = 0; i < 8; i++) begin
      total++;
      if (pix[i] !== 8'(i)) begin bad++; $display("FAIL restart_seed x%0d: got %h want %h", i, pix[i], 8'(i)); end
    end
    $display("reset mid-frame: restart first=%h cnt=%0d", pix[0], frame_cnt);
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_bar();
    test_checker();
    test_solid_reserved();
    test_prbs();
    test_zero_geom();
    test_en_drop();
    test_cfg_change();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
